// File: rtl/bios_wdt_cmd_decoder.sv
// bios_wdt_cmd_decoder: BIOS watchdog write decoder with unlock key, timed window, command pulses/toggles and reject counting
module bios_wdt_cmd_decoder #(
    parameter int                        DATA_W     = 8,
    parameter int                        NUM_CMD    = 4,
    parameter logic [NUM_CMD*DATA_W-1:0] KEY_VEC    = {8'hAA, 8'hFF, 8'h29, 8'h55},
    parameter bit                        UNLOCK_EN  = 1'b1,
    parameter logic [DATA_W-1:0]         UNLOCK_KEY = 8'hA5,
    parameter int                        UNLOCK_WIN = 16
) (
    input  logic               Mclkx,
    input  logic               MainResetN,
    input  logic               WriteBiosWD,
    input  logic [DATA_W-1:0]  BiosWDRegSW,
    input  logic               ClrErr,
    output logic [NUM_CMD-1:0] CmdPulse,
    output logic [NUM_CMD-1:0] CmdToggle,
    output logic               BadKeyPulse,
    output logic               BadKeyToggle,
    output logic [7:0]         BadKeyCnt,
    output logic               Unlocked,
    output logic               WinExpPulse
);
    typedef enum logic {LOCKED, UNLOCKED} state_t;
    localparam logic [15:0] WIN_LD = 16'(UNLOCK_WIN - 1);
    state_t               r_state;
    logic                 r_wr_prev;
    logic [15:0]          r_win_cnt;
    logic                 w_evt;
    logic                 w_unl;
    logic                 w_gate;
    logic                 w_hit;
    logic                 w_rej;
    logic [NUM_CMD-1:0]   w_sel;
    assign w_evt  = WriteBiosWD & ~r_wr_prev;
    assign w_unl  = UNLOCK_EN && (BiosWDRegSW == UNLOCK_KEY);
    assign w_gate = UNLOCK_EN && (r_state == LOCKED);
    assign w_hit  = |w_sel;
    assign w_rej  = w_evt & (w_gate ? ~w_unl : ~w_hit & ~w_unl);
    assign Unlocked = (r_state == UNLOCKED);
    // descending scan so the lowest matching index overrides
    always_comb begin
        w_sel = '0;
        for (int i = NUM_CMD - 1; i >= 0; i--)
            if (BiosWDRegSW == KEY_VEC[i*DATA_W +: DATA_W]) w_sel = NUM_CMD'(1) << i;
    end
    always_ff @(posedge Mclkx or negedge MainResetN) begin
        if (!MainResetN) begin
            r_state      <= LOCKED;
            r_wr_prev    <= 1'b1;
            r_win_cnt    <= '0;
            CmdPulse     <= '0;
            CmdToggle    <= '0;
            BadKeyPulse  <= 1'b0;
            BadKeyToggle <= 1'b0;
            BadKeyCnt    <= '0;
            WinExpPulse  <= 1'b0;
        end else begin
            r_wr_prev   <= WriteBiosWD;
            CmdPulse    <= '0;
            BadKeyPulse <= w_rej;
            WinExpPulse <= 1'b0;
            if (w_rej) BadKeyToggle <= ~BadKeyToggle;
            BadKeyCnt <= ClrErr ? {7'd0, w_rej} : BadKeyCnt + {7'd0, w_rej && BadKeyCnt != 8'hFF};
            if (w_evt) begin
                if (w_gate) begin
                    if (w_unl) begin
                        r_state   <= UNLOCKED;
                        r_win_cnt <= WIN_LD;
                    end
                end else if (w_hit) begin
                    CmdPulse  <= w_sel;
                    CmdToggle <= CmdToggle ^ w_sel;
                    r_state   <= LOCKED;
                end else if (w_unl) begin
                    r_win_cnt <= WIN_LD;
                end else begin
                    r_state <= LOCKED;
                end
            end else if (r_state == UNLOCKED) begin
                if (r_win_cnt != 16'd0) begin
                    r_win_cnt <= r_win_cnt - 16'd1;
                end else begin
                    r_state     <= LOCKED;
                    WinExpPulse <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bios_wdt_cmd_decoder.sv
// tb_bios_wdt_cmd_decoder: directed checks of the BIOS WDT decoder with and without the unlock gate
module tb_bios_wdt_cmd_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b1;
    logic [7:0] data = 8'h00;
    logic       clr = 1'b0;
    logic [3:0] cp, ct, cp0, ct0;
    logic       bkp, bkt, un, wep, bkp0, bkt0, un0, wep0;
    logic [7:0] bcnt, bcnt0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] keys [5] = '{8'h55, 8'h29, 8'hFF, 8'hAA, 8'h07};
    logic [3:0] exp_p [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    always #5 clk = ~clk;
    bios_wdt_cmd_decoder dut (
        .Mclkx(clk), .MainResetN(rst_n), .WriteBiosWD(wr), .BiosWDRegSW(data), .ClrErr(clr),
        .CmdPulse(cp), .CmdToggle(ct), .BadKeyPulse(bkp), .BadKeyToggle(bkt), .BadKeyCnt(bcnt),
        .Unlocked(un), .WinExpPulse(wep)
    );
    bios_wdt_cmd_decoder #(.UNLOCK_EN(1'b0)) dut0 (
        .Mclkx(clk), .MainResetN(rst_n), .WriteBiosWD(wr), .BiosWDRegSW(data), .ClrErr(clr),
        .CmdPulse(cp0), .CmdToggle(ct0), .BadKeyPulse(bkp0), .BadKeyToggle(bkt0), .BadKeyCnt(bcnt0),
        .Unlocked(un0), .WinExpPulse(wep0)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr_byte(input logic [7:0] d, input logic c = 1'b0);
        @(negedge clk);
        wr = 1'b1;
        data = d;
        clr = c;
        @(negedge clk);
        wr = 1'b0;
        clr = 1'b0;
    endtask
    initial begin
        int n;
        #2;
        check("rst_pulse", {cp, bkp, wep}, 0);
        check("rst_state", {ct, bkt, bcnt, un}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_high", {cp, bkp, bcnt, un, cp0, bkp0, bcnt0}, 0);
        end
        wr = 1'b0;
        // unlock then command three cycles later
        wr_byte(8'hA5);
        check("unl_rise", un, 1);
        @(negedge clk);
        check("unl_hold", un, 1);
        wr_byte(8'h29);
        check("cmd1_pulse", {cp, bkp}, {4'b0010, 1'b0});
        check("cmd1_tog", ct, 4'b0010);
        check("cmd1_lock", un, 0);
        @(negedge clk);
        check("cmd1_end", cp, 0);
        // unused window
        wr_byte(8'hA5);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!un) break;
            n++;
        end
        check("win_len", n, 16);
        check("win_exp", wep, 1);
        @(negedge clk);
        check("win_exp_end", wep, 0);
        wr_byte(8'h55);
        check("lock_rej", {bkp, bkt, bcnt}, {1'b1, 1'b1, 8'd1});
        check("lock_rej_tog", {cp, ct}, {4'b0000, 4'b0010});
        // command on the last window cycle
        wr_byte(8'hA5);
        repeat (14) @(negedge clk);
        wr_byte(8'h55);
        check("edge_cmd", {cp, wep, un}, {4'b0001, 1'b0, 1'b0});
        check("edge_tog", ct, 4'b0011);
        @(negedge clk);
        check("edge_noexp", wep, 0);
        // reload and bad key while unlocked
        wr_byte(8'hA5);
        wr_byte(8'hA5);
        check("reload", {un, bkp, bcnt}, {1'b1, 1'b0, 8'd1});
        wr_byte(8'h07);
        check("unl_rej", {un, bkp, bkt, bcnt}, {1'b0, 1'b1, 1'b0, 8'd2});
        wr_byte(8'h29);
        check("key_locked", {cp, ct, bkp, bcnt}, {4'b0000, 4'b0011, 1'b1, 8'd3});
        // saturation
        n = 0;
        for (int i = 0; i < 300; i++) begin
            wr_byte(8'h12);
            n += int'(bkp);
        end
        check("sat_pulses", n, 300);
        check("sat_cnt", bcnt, 255);
        check("sat_tog", bkt, 1);
        wr_byte(8'h12, 1'b1);
        check("clr_rej", bcnt, 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_only", bcnt, 0);
        // asynchronous reset mid-window
        wr_byte(8'hA5);
        check("pre_rst", un, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", {un, ct, bkt, bcnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // decoder without unlock gate
        for (int i = 0; i < 5; i++) begin
            wr_byte(keys[i]);
            check("direct_pulse", {cp0, bkp0}, {exp_p[i], keys[i] == 8'h07});
        end
        check("direct_tog", {ct0, bkt0, bcnt0}, {4'b1111, 1'b1, 8'd1});
        check("gated_rej", {ct, bcnt}, {4'b0000, 8'd5});
        @(negedge clk);
        wr = 1'b1;
        data = 8'h55;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 5) wr = 1'b0;
            n += int'(cp0[0]);
        end
        check("long_strobe", n, 1);
        check("long_tog", ct0, 4'b1110);
        wr_byte(8'hA5);
        check("direct_a5", {un0, bkp0, bcnt0}, {1'b0, 1'b1, 8'd2});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
